// File: rtl/spi_wb_cmd_sequencer.sv
`default_nettype none
// ==========================================================================
// spi_wb_cmd_sequencer : framed byte commands -> single-byte WB writes, with
// retry/backoff and CS gaps. Optional RX capture: SPI_SEQ_RX_CAPTURE_EN. Rev 1.0
// ==========================================================================
module spi_wb_cmd_sequencer #(
  parameter int NUM_CHIP_SELECTS = 3,
  parameter int TX_DEPTH         = 8,
  parameter int RX_DEPTH         = 8,
  parameter int MAX_RETRIES      = 4,
  parameter int BACKOFF_CYCLES   = 8,
  parameter int CS_GAP           = 4,
  localparam int CSW = (NUM_CHIP_SELECTS > 1) ? $clog2(NUM_CHIP_SELECTS) : 1
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [CSW-1:0] cmd_cs,
  input  logic [7:0]     cmd_data,
  input  logic           cmd_last,
  output logic           STB_O,
  output logic           WE_O,
  output logic [7:0]     ADR_O,
  output logic [7:0]     DAT_O,
  input  logic           ACK_I,
  input  logic           RTY_I,
  input  logic [7:0]     DAT_I,
  output logic           rx_valid,
  input  logic           rx_ready,
  output logic [7:0]     rx_data,
  output logic           rx_last,
  output logic           busy,
  output logic           err,
  input  logic           err_clr
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TW  = 1 + CSW + 8;
  localparam int RW  = $clog2(MAX_RETRIES + 2);
  localparam int BW  = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam int GW  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [BW-1:0] BO_LAST   = BW'(BACKOFF_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, BACKOFF, GAP, FLUSH} state_t;
  state_t state;

  logic [RW-1:0] retry_cnt;
  logic [BW-1:0] bo_cnt;
  logic [GW-1:0] gap_cnt;
  logic          ready_en;
  logic          rx_space;

  // TX FIFO: entry = {last, cs, data}
  logic [TW-1:0]  tx_mem [TX_DEPTH];
  logic [TAW:0]   tx_wp, tx_rp;
  logic           tx_full, tx_empty, tx_push, tx_pop;
  logic [TW-1:0]  head;
  logic           head_last;
  logic [CSW-1:0] head_cs;
  logic [7:0]     head_data;

  assign tx_empty  = (tx_wp == tx_rp);
  assign tx_full   = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
  assign cmd_ready = ready_en && !tx_full;
  assign tx_push   = cmd_valid && cmd_ready;
  assign tx_pop    = ((state == ISSUE) && ACK_I) || ((state == FLUSH) && !tx_empty);
  assign head      = tx_mem[tx_rp[TAW-1:0]];
  assign head_last = head[TW-1];
  assign head_cs   = head[8 +: CSW];
  assign head_data = head[7:0];
  assign busy      = (state != IDLE) || !tx_empty;

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= {cmd_last, cmd_cs, cmd_data};
  end

`ifdef SPI_SEQ_RX_CAPTURE_EN
  localparam int RAW = $clog2(RX_DEPTH);
  logic [8:0]   rx_mem [RX_DEPTH];
  logic [RAW:0] rx_wp, rx_rp;
  logic         rx_push, rx_pop, rx_full;
  logic [8:0]   rx_head;

  assign rx_push  = (state == ISSUE) && ACK_I;
  assign rx_valid = (rx_wp != rx_rp);
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
  assign rx_space = !rx_full;
  assign rx_head  = rx_mem[rx_rp[RAW-1:0]];
  assign rx_data  = rx_valid ? rx_head[7:0] : 8'h00;
  assign rx_last  = rx_valid && rx_head[8];

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= {head_last, DAT_I};
  end
`else
  localparam int unused_rx_depth = RX_DEPTH;
  logic unused_rx;
  assign unused_rx = ^{DAT_I, rx_ready};
  assign rx_valid  = 1'b0;
  assign rx_data   = 8'h00;
  assign rx_last   = 1'b0;
  assign rx_space  = 1'b1;
`endif

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state     <= IDLE;
      STB_O     <= 1'b0;
      WE_O      <= 1'b0;
      ADR_O     <= 8'h00;
      DAT_O     <= 8'h00;
      retry_cnt <= '0;
      bo_cnt    <= '0;
      gap_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      // a same-cycle abort below overrides this clear
      if (err_clr) err <= 1'b0;
      case (state)
        IDLE: begin
          if (!tx_empty && rx_space) begin
            state <= ISSUE;
            STB_O <= 1'b1;
            WE_O  <= 1'b1;
            ADR_O <= 8'(head_cs);
            DAT_O <= head_data;
          end
        end
        ISSUE: begin
          if (ACK_I) begin
            STB_O     <= 1'b0;
            WE_O      <= 1'b0;
            retry_cnt <= '0;
            gap_cnt   <= '0;
            state     <= head_last ? GAP : IDLE;
          end else if (RTY_I) begin
            STB_O <= 1'b0;
            WE_O  <= 1'b0;
            if (retry_cnt >= RETRY_MAX) begin
              retry_cnt <= '0;
              err       <= 1'b1;
              state     <= FLUSH;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              bo_cnt    <= '0;
              state     <= BACKOFF;
            end
          end
        end
        BACKOFF: begin
          if (bo_cnt == BO_LAST) begin
            state <= ISSUE;
            STB_O <= 1'b1;
            WE_O  <= 1'b1;
          end else begin
            bo_cnt <= bo_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        FLUSH: begin
          if (!tx_empty && head_last) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_wb_cmd_sequencer.sv
`default_nettype none
// tb_spi_wb_cmd_sequencer : directed checks of the WB command sequencer
// against a small bench-side Wishbone responder.
module tb_spi_wb_cmd_sequencer;
  localparam int CSW = 2;
`ifdef SPI_SEQ_RX_CAPTURE_EN
  localparam bit RXCAP = 1'b1;
`else
  localparam bit RXCAP = 1'b0;
`endif

  logic           CLK_I = 1'b0;
  logic           RST_I = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [CSW-1:0] cmd_cs = '0;
  logic [7:0]     cmd_data = 8'h00;
  logic           cmd_last = 1'b0;
  logic           STB_O, WE_O;
  logic [7:0]     ADR_O, DAT_O;
  logic           ACK_I, RTY_I;
  logic [7:0]     DAT_I;
  logic           rx_valid;
  logic           rx_ready = 1'b1;
  logic [7:0]     rx_data;
  logic           rx_last;
  logic           busy, err;
  logic           err_clr = 1'b0;

  always #5 CLK_I = ~CLK_I;

  spi_wb_cmd_sequencer dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cs(cmd_cs),
    .cmd_data(cmd_data), .cmd_last(cmd_last),
    .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .ACK_I(ACK_I), .RTY_I(RTY_I), .DAT_I(DAT_I),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_last(rx_last),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Responder: drives shortly after each rising edge, replies to a strobe
  // after ack_delay cycles, first with rty_left retries, then an ACK.
  int ack_delay = 0;
  int rty_left  = 0;
  bit resp_hold = 1'b0;
  int wait_cnt  = 0;

  initial begin
    ACK_I = 1'b0; RTY_I = 1'b0; DAT_I = 8'h00;
    forever begin
      @(posedge CLK_I); #2;
      ACK_I = 1'b0; RTY_I = 1'b0;
      if (STB_O && !resp_hold) begin
        if (wait_cnt < ack_delay) wait_cnt++;
        else begin
          wait_cnt = 0;
          if (rty_left > 0) begin RTY_I = 1'b1; rty_left--; end
          else begin ACK_I = 1'b1; DAT_I = ~DAT_O; end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  logic [15:0] acked[$];
  logic [8:0]  rxq[$];
  int          rty_seen = 0;

  always @(negedge CLK_I) begin
    if (STB_O && ACK_I) acked.push_back({ADR_O, DAT_O});
    if (STB_O && RTY_I && !ACK_I) rty_seen++;
    if (rx_valid && rx_ready) rxq.push_back({rx_last, rx_data});
  end

  task automatic tick();
    @(posedge CLK_I); #1;
  endtask

  task automatic push(input logic [CSW-1:0] cs, input logic [7:0] d, input logic l);
    int n = 0;
    cmd_valid = 1'b1; cmd_cs = cs; cmd_data = d; cmd_last = l;
    while (!cmd_ready && n < 500) begin tick(); n++; end
    check("push_ok", 32'(n < 500), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_stb_high();
    int n = 0;
    while (!STB_O && n < 500) begin tick(); n++; end
    check("stb_seen", 32'(n < 500), 1);
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!ACK_I && n < 500) begin tick(); n++; end
    check("ack_seen", 32'(n < 500), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    check("idle_seen", 32'(n < 2000), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, r0, n;

    // reset state
    tick(); tick();
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_wb", {STB_O, WE_O, ADR_O, DAT_O}, 0);
    check("rst_rx", {rx_valid, rx_data, rx_last}, 0);
    check("rst_busy_err", {busy, err}, 0);
    RST_I = 1'b1;
    tick();
    check("post_rst_ready", 32'(cmd_ready), 1);

    // 1: two-byte frame on cs=2, ACK after 3 cycles
    ack_delay = 3; base = acked.size(); rxq.delete();
    push(2'd2, 8'hA5, 1'b0);
    push(2'd2, 8'h3C, 1'b1);
    wait_stb_high();
    check("t1_adr", 32'(ADR_O), 32'h02);
    check("t1_dat0", 32'(DAT_O), 32'hA5);
    check("t1_we", 32'(WE_O), 1);
    wait_ack();
    wait_stb_high();
    check("t1_dat1", 32'(DAT_O), 32'h3C);
    wait_ack();
    n = 0;
    while (busy && n < 50) begin n++; tick(); end
    check("t1_gap_len", n, 4);
    check("t1_nacked", acked.size() - base, 2);
    check("t1_ack0", 32'(acked[base]), 32'h02A5);
    check("t1_ack1", 32'(acked[base+1]), 32'h023C);
    if (RXCAP) begin
      check("t1_nrx", rxq.size(), 2);
      check("t1_rx0", 32'(rxq[0]), 32'h05A);
      check("t1_rx1", 32'(rxq[1]), 32'h1C3);
    end else begin
      check("t1_nrx", rxq.size(), 0);
    end

    // 2: one retry then ACK
    ack_delay = 0; rty_left = 1; r0 = rty_seen;
    push(2'd1, 8'h77, 1'b1);
    n = 0;
    while (!RTY_I && n < 100) begin tick(); n++; end
    check("t2_rty_seen", 32'(n < 100), 1);
    n = 0;
    while (!STB_O && n < 100) begin n++; tick(); end
    check("t2_backoff_len", n, 8);
    check("t2_dat", 32'(DAT_O), 32'h77);
    check("t2_adr", 32'(ADR_O), 32'h01);
    wait_ack();
    wait_idle();
    check("t2_err", 32'(err), 0);
    check("t2_nrty", rty_seen - r0, 1);

    // 3: five retries abort a three-byte frame; next frame on cs=0 is normal
    rty_left = 5; r0 = rty_seen; base = acked.size(); rxq.delete();
    push(2'd1, 8'h11, 1'b0);
    push(2'd1, 8'h22, 1'b0);
    push(2'd1, 8'h33, 1'b1);
    n = 0;
    while (!err && n < 500) begin tick(); n++; end
    check("t3_err_set", 32'(err), 1);
    wait_idle();
    check("t3_nrty", rty_seen - r0, 5);
    check("t3_nacked", acked.size() - base, 0);
    check("t3_nrx", rxq.size(), 0);
    check("t3_rx_valid", 32'(rx_valid), 0);
    push(2'd0, 8'h44, 1'b1);
    wait_idle();
    check("t3_next_nacked", acked.size() - base, 1);
    check("t3_next_ack", 32'(acked[base]), 32'h0044);
    check("t3_err_sticky", 32'(err), 1);
    check("t3_next_nrx", rxq.size(), RXCAP ? 1 : 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t3_err_clr", 32'(err), 0);

    // 4: fill TX with ACK held off, then release
    resp_hold = 1'b1; base = acked.size();
    for (int i = 0; i < 8; i++) push(2'd1, 8'h10 + 8'(i), 1'b0);
    check("t4_full", 32'(cmd_ready), 0);
    check("t4_stb_held", {STB_O, DAT_O}, 32'h110);
    resp_hold = 1'b0;
    push(2'd1, 8'h18, 1'b1);
    wait_idle();
    check("t4_nacked", acked.size() - base, 9);
    for (int i = 0; i < 9; i++) check("t4_order", 32'(acked[base+i]), 32'h0110 + i);

    // 5: ten single-byte frames with the RX consumer stalled
    rx_ready = 1'b0; base = acked.size(); rxq.delete();
    for (int i = 0; i < 10; i++) push(2'd0, 8'hA0 + 8'(i), 1'b1);
    for (int i = 0; i < 100; i++) tick();
    if (RXCAP) begin
      check("t5_stall_nacked", acked.size() - base, 8);
      check("t5_stall_stb", 32'(STB_O), 0);
      check("t5_stall_rxv", 32'(rx_valid), 1);
    end
    rx_ready = 1'b1;
    wait_idle();
    tick(); tick(); tick();
    check("t5_nacked", acked.size() - base, 10);
    if (RXCAP) begin
      check("t5_nrx", rxq.size(), 10);
      for (int i = 0; i < 10; i++) check("t5_rx", 32'(rxq[i]), 32'h15F - i);
    end else begin
      check("t5_rxv", 32'(rx_valid), 0);
    end

    // 6: reset while a strobe is outstanding
    rx_ready = 1'b0;
    push(2'd2, 8'h66, 1'b1);
    wait_idle();
    check("t6_rxv_pre", 32'(rx_valid), RXCAP ? 1 : 0);
    resp_hold = 1'b1; base = acked.size();
    push(2'd2, 8'h77, 1'b0);
    wait_stb_high();
    RST_I = 1'b0;
    tick();
    check("t6_stb", 32'(STB_O), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_rxv", 32'(rx_valid), 0);
    check("t6_ready", 32'(cmd_ready), 0);
    resp_hold = 1'b0; RST_I = 1'b1;
    tick();
    check("t6_ready_back", 32'(cmd_ready), 1);
    for (int i = 0; i < 20; i++) tick();
    check("t6_discarded", acked.size() - base, 0);
    check("t6_idle", {busy, STB_O, err}, 0);
    rx_ready = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
